// File: rtl/flex_updown_counter.sv
`default_nettype none
//==============================================================================
// Module   : flex_updown_counter
// Summary  : Width-generic up/down counter with programmable terminal value,
//            synchronous clear, parallel load, registered terminal-count flag
//            and a one-cycle wrap pulse.
// Options  : define FLEX_UPDOWN_SATURATE_EN to saturate instead of wrapping.
// Revision : 1.0 - initial release
//==============================================================================
module flex_updown_counter #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned RST_VAL      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_up,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] c_rst_cnt = NUM_CNT_BITS'(RST_VAL);
  localparam logic [NUM_CNT_BITS-1:0] c_zero    = '0;
  localparam logic [NUM_CNT_BITS-1:0] c_one     = NUM_CNT_BITS'(1);

`ifdef FLEX_UPDOWN_SATURATE_EN
  localparam logic [NUM_CNT_BITS-1:0] c_down_term = c_zero;
`else
  localparam logic [NUM_CNT_BITS-1:0] c_down_term = c_one;
`endif

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    wrap_q, wrap_d;
  logic [NUM_CNT_BITS-1:0] w_term;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = c_rst_cnt;
    end else if (load) begin
      count_d = load_val;
    end else if (count_enable) begin
      if (rollover_val == c_zero) begin
        count_d = c_zero;
      end else if (count_up) begin
        if (count_q >= rollover_val) begin
`ifdef FLEX_UPDOWN_SATURATE_EN
          count_d = rollover_val;
`else
          count_d = c_one;
`endif
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
`ifdef FLEX_UPDOWN_SATURATE_EN
        // Down saturates at zero; stepping from one reaches zero normally.
        if (count_q == c_zero) begin
          count_d = c_zero;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - c_one;
        end
`else
        if (count_q <= c_one) begin
          count_d = rollover_val;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - c_one;
        end
`endif
      end
    end
  end

  // Flag tracks the next count against the direction-dependent terminal value.
  assign w_term = count_up ? rollover_val : c_down_term;
  assign flag_d = (rollover_val != c_zero) && (count_d == w_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= c_rst_cnt;
      flag_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_flex_updown_counter.sv
`default_nettype none
//==============================================================================
// Module   : tb_flex_updown_counter
// Summary  : Self-checking bench for flex_updown_counter (4 bits, reset 0).
// Revision : 1.0 - initial release
//==============================================================================
module tb_flex_updown_counter;

  localparam int W      = 4;
  localparam int RSTV   = 0;
`ifdef FLEX_UPDOWN_SATURATE_EN
  localparam int DN_TERM = 0;
`else
  localparam int DN_TERM = 1;
`endif

  logic         clk = 1'b0;
  logic         rst, clear, load, count_enable, count_up;
  logic [W-1:0] load_val, rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag, wrap_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, integer-valued.
  int m_cnt  = RSTV;
  int m_flag = 0;
  int m_wrap = 0;

  flex_updown_counter #(.NUM_CNT_BITS(W), .RST_VAL(RSTV)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_up     (count_up),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; clear = 0; load = 0; count_enable = 0;
  endtask

  // Advance one edge; the model consumes the same inputs the DUT sees.
  task automatic tick();
    int rv, nxt, w, f;
    rv  = int'(rollover_val);
    nxt = m_cnt;
    w   = 0;
    if (clear) nxt = RSTV;
    else if (load) nxt = int'(load_val);
    else if (count_enable) begin
      if (rv == 0) nxt = 0;
      else if (count_up) begin
        if (m_cnt >= rv) begin
`ifdef FLEX_UPDOWN_SATURATE_EN
          nxt = rv;
`else
          nxt = 1;
`endif
          w = 1;
        end else nxt = m_cnt + 1;
      end else begin
`ifdef FLEX_UPDOWN_SATURATE_EN
        if (m_cnt == 0) begin nxt = 0; w = 1; end
        else nxt = m_cnt - 1;
`else
        if (m_cnt <= 1) begin nxt = rv; w = 1; end
        else nxt = m_cnt - 1;
`endif
      end
    end
    f = (rv != 0 && nxt == (count_up ? rv : DN_TERM)) ? 1 : 0;
    if (rst) begin nxt = RSTV; w = 0; f = 0; end
    @(posedge clk);
    #1;
    m_cnt = nxt; m_wrap = w; m_flag = f;
  endtask

  task automatic test_reset();
    idle(); rst = 1; load_val = 0; count_up = 1; rollover_val = 5;
    tick(); tick();
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_init: got cnt=%0d flag=%b wrap=%b, expected 0 0 0",
               count_out, rollover_flag, wrap_pulse);
    end
    rst = 0; count_enable = 1;
    tick(); tick(); tick();
    n_checks++;
    if (count_out !== 4'd3) begin
      n_errors++;
      $display("FAIL reset_precount: got %0d expected 3", count_out);
    end
    rst = 1; load = 1; load_val = 7;
    tick();
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midrun: got cnt=%0d flag=%b wrap=%b, expected 0 0 0",
               count_out, rollover_flag, wrap_pulse);
    end
    idle();
  endtask

`ifndef FLEX_UPDOWN_SATURATE_EN
  task automatic test_up_wrap();
    int exp_c [6] = '{1, 2, 3, 4, 5, 1};
    idle(); clear = 1; tick(); idle();
    rollover_val = 5; count_up = 1; count_enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (count_out !== 4'(exp_c[i]) || rollover_flag !== (exp_c[i] == 5) ||
          wrap_pulse !== (i == 5)) begin
        n_errors++;
        $display("FAIL up_wrap edge %0d: got cnt=%0d flag=%b wrap=%b, expected %0d %b %b",
                 i + 1, count_out, rollover_flag, wrap_pulse,
                 exp_c[i], exp_c[i] == 5, i == 5);
      end
    end
    idle();
  endtask

  task automatic test_down_wrap();
    int exp_c [4] = '{2, 1, 5, 4};
    idle(); load = 1; load_val = 3; rollover_val = 5; count_up = 0; tick();
    idle(); count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (count_out !== 4'(exp_c[i]) || rollover_flag !== (i == 1) ||
          wrap_pulse !== (i == 2)) begin
        n_errors++;
        $display("FAIL down_wrap edge %0d: got cnt=%0d flag=%b wrap=%b, expected %0d %b %b",
                 i + 1, count_out, rollover_flag, wrap_pulse, exp_c[i], i == 1, i == 2);
      end
    end
    idle();
  endtask

  task automatic test_boundary_above();
    idle(); rollover_val = 5; count_up = 1; load = 1; load_val = 12; tick();
    n_checks++;
    if (count_out !== 4'd12) begin
      n_errors++;
      $display("FAIL load_above: got %0d expected 12", count_out);
    end
    idle(); count_enable = 1; tick();
    n_checks++;
    if (count_out !== 4'd1 || wrap_pulse !== 1'b1 || rollover_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_from_above: got cnt=%0d wrap=%b flag=%b, expected 1 1 0",
               count_out, wrap_pulse, rollover_flag);
    end
    idle();
  endtask
`else
  task automatic test_saturate();
    idle(); clear = 1; tick(); idle();
    rollover_val = 15; count_up = 1; count_enable = 1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++;
      if (count_out !== 4'((i + 1 > 15) ? 15 : i + 1) || wrap_pulse !== (i >= 15)) begin
        n_errors++;
        $display("FAIL sat_up edge %0d: got cnt=%0d wrap=%b", i + 1, count_out, wrap_pulse);
      end
    end
    idle(); clear = 1; tick(); idle();
    count_up = 0; count_enable = 1; tick();
    n_checks++;
    if (count_out !== 4'd0 || wrap_pulse !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_down: got cnt=%0d wrap=%b expected 0 1", count_out, wrap_pulse);
    end
    idle();
  endtask
`endif

  task automatic test_priority();
    idle(); rollover_val = 10; count_up = 1;
    load = 1; load_val = 4; tick();
    clear = 1; load = 1; load_val = 9; count_enable = 1; tick();
    n_checks++;
    if (count_out !== 4'd0 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_clear: got cnt=%0d wrap=%b expected 0 0", count_out, wrap_pulse);
    end
    clear = 0; tick();
    n_checks++;
    if (count_out !== 4'd9 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_load: got cnt=%0d wrap=%b expected 9 0", count_out, wrap_pulse);
    end
    idle(); tick();
    n_checks++;
    if (count_out !== 4'd9 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL hold: got cnt=%0d wrap=%b expected 9 0", count_out, wrap_pulse);
    end
  endtask

  task automatic test_zero_terminal();
    idle(); load = 1; load_val = 6; rollover_val = 5; tick();
    idle(); rollover_val = 0; count_enable = 1; count_up = 1; tick();
    n_checks++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_term: got cnt=%0d flag=%b wrap=%b, expected 0 0 0",
               count_out, rollover_flag, wrap_pulse);
    end
    idle();
  endtask

  task automatic test_random();
    idle(); rst = 1; tick(); idle();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      clear        = ($urandom_range(0, 24) == 0);
      load         = ($urandom_range(0, 9) == 0);
      load_val     = 4'($urandom);
      count_enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) count_up = ~count_up;
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       rollover_val = 4'd0;
          1:       rollover_val = 4'd15;
          default: rollover_val = 4'($urandom_range(1, 14));
        endcase
      end
      tick();
      n_checks++;
      if (count_out !== 4'(m_cnt) || rollover_flag !== 1'(m_flag) ||
          wrap_pulse !== 1'(m_wrap)) begin
        n_errors++;
        $display("FAIL random cycle %0d: got cnt=%0d flag=%b wrap=%b, expected %0d %0d %0d",
                 i, count_out, rollover_flag, wrap_pulse, m_cnt, m_flag, m_wrap);
      end
    end
    idle();
  endtask

  initial begin
    idle(); count_up = 1; load_val = 0; rollover_val = 5;
    test_reset();
`ifndef FLEX_UPDOWN_SATURATE_EN
    test_up_wrap();
    test_down_wrap();
    test_boundary_above();
`else
    test_saturate();
`endif
    test_priority();
    test_zero_terminal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
- Parametrised successor to the team's flexible counter.
- Width-generic up/down counter with programmable rollover value, synchronous clear, parallel load, a registered terminal-count flag and a single-cycle wrap pulse.
- Used as the timing and bit-count engine in datapath controllers, such as serial shift timers and packet byte counters, where both count directions and mid-run preload are needed.

Parameters:
- NUM_CNT_BITS, 4, width of count_out, rollover_val and load_val; legal range 2..32.
- RST_VAL, 0, value count_out takes on reset and clear; must be <= 2**NUM_CNT_BITS-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear to RST_VAL.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  NUM_CNT_BITS  value loaded when load=1.
- count_enable  input  1  advance the count by one step.
- count_up  input  1  direction: 1 = up, 0 = down.
- rollover_val  input  NUM_CNT_BITS  terminal value; sampled every cycle.
- count_out  output  NUM_CNT_BITS  current count (registered).
- rollover_flag  output  1  registered terminal-count flag.
- wrap_pulse  output  1  registered one-cycle pulse on the edge where a wrap occurred.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On rst=1 at a rising edge, count_out=RST_VAL, rollover_flag=0 and wrap_pulse=0, regardless of all other inputs.
- Priority per edge: rst > clear > load > count_enable > hold.
- clear=1: count_out=RST_VAL, wrap_pulse=0.
- load=1: count_out=load_val, wrap_pulse=0. Loaded values above rollover_val are legal.
- Count, up (count_enable=1, count_up=1):
  - If count_out >= rollover_val: next=1 and wrap_pulse=1.
  - Else: next=count_out+1.
- Count, down (count_enable=1, count_up=0):
  - If count_out <= 1: next=rollover_val and wrap_pulse=1.
  - Else: next=count_out-1.
- Zero terminal value: if rollover_val==0, count_enable forces next=0 with wrap_pulse=0. Clear and load still act.
- Hold: with count_enable=0, count_out holds and wrap_pulse=0.
- rollover_flag is updated every edge, including hold cycles, from the next count value and the count_up value sampled at that edge:
  - up: flag=(next==rollover_val) and rollover_val!=0.
  - down: flag=(next==1) and rollover_val!=0.
- Latency: count_out, rollover_flag and wrap_pulse all reflect an edge's inputs immediately after that edge. There is no combinational path from inputs to outputs.
- Arithmetic: unsigned, NUM_CNT_BITS wide. Never wraps through 2**N-1 or 0 except via the rules above; rollover_val = 2**N-1 is legal.
- Mid-run changes: a direction change or rollover_val change takes effect on the next enabled edge using the current count_out.
- Reset mid-count: overrides all operations on that edge, with the reset values above.

Optional Feature:
- Macro: FLEX_UPDOWN_SATURATE_EN.
- When defined, counting saturates instead of wrapping:
  - up at count_out >= rollover_val: next=rollover_val.
  - down at count_out==0: next=0; down from 1 gives 0.
  - wrap_pulse=1 on any enabled edge where the count was held by saturation.
  - rollover_flag asserts at rollover_val (up) or 0 (down).
- When undefined: wrap behaviour as specified above; no saturation logic is synthesised.

Test Plan (NUM_CNT_BITS=4, RST_VAL=0):
- Reset: run counting, then rst=1 for 1 edge with count_enable=1, load=1 -> count_out=0, rollover_flag=0, wrap_pulse=0 on that edge.
- Up wrap: rollover_val=5, count_up=1, enable for 6 edges -> count_out 1,2,3,4,5,1; rollover_flag=1 only while count_out=5; wrap_pulse=1 only after the 6th edge.
- Down wrap: load_val=3 then enable down, rollover_val=5 for 4 edges -> 2,1,5,4; rollover_flag=1 while count_out=1; wrap_pulse=1 after the edge that produced 5.
- Priority: clear=1, load=1, load_val=9, count_enable=1 on the same edge -> count_out=0. Then load=1 with count_enable=1 -> count_out=9.
- Boundaries: load 12 with rollover_val=5, then one up edge -> count_out=1, wrap_pulse=1. Then rollover_val=0 and enable -> count_out=0, flag=0, pulse=0.
- Saturate (FLEX_UPDOWN_SATURATE_EN defined): rollover_val=15, up, 17 edges -> count_out stays 15 from edge 15 on, wrap_pulse=1 on edges 16 and 17. Down from 0 -> count_out holds 0.
